// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: state encoding,
// frame header nibbles, shift function codes and the idle-timeout default.
package alu_op_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_A0,
    GET_A1,
    GET_B0,
    GET_B1,
    EXEC,
    CAPT,
    SEND_LO,
    SEND_HI
  } state_t;

  localparam logic [3:0] HDR_LOAD    = 4'hA;
  localparam logic [3:0] HDR_REUSE   = 4'hB;
  localparam logic [3:0] FUN_SHR     = 4'hD;
  localparam logic [3:0] FUN_SHL     = 4'hE;
  localparam logic [3:0] FUN_DEFAULT = 4'hF;

  localparam int TIMEOUT_DEFAULT = 255;

  // Shift operations take only operand A; B keeps its stored value.
  function automatic logic is_shift(input logic [3:0] fun);
    return (fun == FUN_SHR) || (fun == FUN_SHL);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_timer.sv
// Idle-cycle counter for operand collection; saturates at LIMIT and
// raises expired until cleared.
module alu_seq_timer
  import alu_op_sequencer_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] r_count;

  assign expired = (r_count == 8'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (clear) begin
      r_count <= 8'd0;
    end else if (run && !expired) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Frame-driven sequencer: collects header and operand bytes, drives an
// external registered ALU for one cycle, then returns the 16-bit result as two bytes.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic [3:0]  ALU_FUN,
  output logic        ALU_EN,
  input  logic [15:0] ALU_OUT,
  output logic        BUSY,
  output logic        ERR
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_result;
  logic [3:0]  r_fun;
  logic        r_err;
  logic        w_err;
  logic        w_in_get;
  logic        w_rx_acc;
  logic        w_expired;
  logic        w_load_fun;
  logic        w_load_a_lo;
  logic        w_load_a_hi;
  logic        w_load_b_lo;
  logic        w_load_b_hi;

  assign w_in_get = (r_state == GET_A0) || (r_state == GET_A1) ||
                    (r_state == GET_B0) || (r_state == GET_B1);
  // Held low during reset so no byte looks accepted while the block is cleared.
  assign RX_READY = (w_in_get || (r_state == IDLE)) && !RST;
  assign w_rx_acc = RX_VALID && RX_READY;

  assign TX_VALID = (r_state == SEND_LO) || (r_state == SEND_HI);
  assign TX_DATA  = (r_state == SEND_HI) ? r_result[15:8] :
                    (r_state == SEND_LO) ? r_result[7:0]  : 8'h00;
  assign ALU_A    = r_a;
  assign ALU_B    = r_b;
  assign ALU_FUN  = r_fun;
  assign ALU_EN   = (r_state == EXEC);
  assign BUSY     = (r_state != IDLE);
  assign ERR      = r_err;

  alu_seq_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .clear  (!w_in_get || w_rx_acc),
    .run    (w_in_get),
    .expired(w_expired)
  );

  always_comb begin
    w_next      = r_state;
    w_err       = 1'b0;
    w_load_fun  = 1'b0;
    w_load_a_lo = 1'b0;
    w_load_a_hi = 1'b0;
    w_load_b_lo = 1'b0;
    w_load_b_hi = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rx_acc) begin
          if (RX_DATA[7:4] == HDR_LOAD) begin
            w_load_fun = 1'b1;
            w_next     = GET_A0;
          end else if (RX_DATA[7:4] == HDR_REUSE) begin
            w_load_fun = 1'b1;
            w_next     = EXEC;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      GET_A0: begin
        if (w_rx_acc) begin
          w_load_a_lo = 1'b1;
          w_next      = GET_A1;
        end else if (w_expired) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      GET_A1: begin
        if (w_rx_acc) begin
          w_load_a_hi = 1'b1;
          w_next      = is_shift(r_fun) ? EXEC : GET_B0;
        end else if (w_expired) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      GET_B0: begin
        if (w_rx_acc) begin
          w_load_b_lo = 1'b1;
          w_next      = GET_B1;
        end else if (w_expired) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      GET_B1: begin
        if (w_rx_acc) begin
          w_load_b_hi = 1'b1;
          w_next      = EXEC;
        end else if (w_expired) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      EXEC:    w_next = CAPT;
      CAPT:    w_next = SEND_LO;
      SEND_LO: if (TX_READY) w_next = SEND_HI;
      SEND_HI: if (TX_READY) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands and function change only on accepted bytes; the result is
  // captured from the ALU during CAPT, one cycle after the ALU_EN cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_fun    <= FUN_DEFAULT;
      r_result <= 16'h0000;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      if (w_load_fun)  r_fun      <= RX_DATA[3:0];
      if (w_load_a_lo) r_a[7:0]   <= RX_DATA;
      if (w_load_a_hi) r_a[15:8]  <= RX_DATA;
      if (w_load_b_lo) r_b[7:0]   <= RX_DATA;
      if (w_load_b_hi) r_b[15:8]  <= RX_DATA;
      if (r_state == CAPT) r_result <= ALU_OUT;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a table of frames with
// hand-computed results plus directed bad-header, timeout, stall and reset sequences.
module tb_alu_op_sequencer;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic [15:0] ALU_A;
  logic [15:0] ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        BUSY;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  int   cyc = 0;
  int   rxCount = 0;
  int   lastAcc = 0;
  int   enCount = 0;
  int   enCyc = 0;
  int   txRise = 0;
  int   errCount = 0;
  logic prevTxValid = 1'b0;

  typedef struct {
    logic [7:0]  hdr;
    int          nOps;
    logic [31:0] ops;
    logic [15:0] expRes;
    logic [15:0] expA;
    logic [15:0] expB;
    logic [3:0]  expFun;
  } frameVec_t;

  frameVec_t vecs[6];

  alu_op_sequencer dut (
    .CLK     (CLK),
    .RST     (RST),
    .RX_DATA (RX_DATA),
    .RX_VALID(RX_VALID),
    .RX_READY(RX_READY),
    .TX_DATA (TX_DATA),
    .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .ALU_A   (ALU_A),
    .ALU_B   (ALU_B),
    .ALU_FUN (ALU_FUN),
    .ALU_EN  (ALU_EN),
    .ALU_OUT (ALU_OUT),
    .BUSY    (BUSY),
    .ERR     (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stand-in for the external registered ALU.
  function automatic logic [15:0] aluModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] f);
    case (f)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a * b;
      4'h4:    return a & b;
      4'h5:    return a | b;
      4'h6:    return a ^ b;
      4'hD:    return a >> b[3:0];
      4'hE:    return a << b[3:0];
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) ALU_OUT <= 16'h0000;
    else if (ALU_EN) ALU_OUT <= aluModel(ALU_A, ALU_B, ALU_FUN);
  end

  // Per-cycle activity monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (RX_VALID && RX_READY) begin
      rxCount <= rxCount + 1;
      lastAcc <= cyc;
    end
    if (ALU_EN) begin
      enCount <= enCount + 1;
      enCyc   <= cyc;
    end
    if (TX_VALID && !prevTxValid) txRise <= cyc;
    prevTxValid <= TX_VALID;
    if (ERR) errCount <= errCount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    n = 0;
    while (!RX_READY && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!RX_READY) begin
      checks++;
      errors++;
      $display("[TB] FAIL rx_ready_wait: got 0, want 1 for byte %0h", b);
      RX_VALID = 1'b0;
    end else begin
      @(posedge CLK); #1;
      RX_VALID = 1'b0;
    end
  endtask

  task automatic collectByte(output logic [7:0] b);
    int n;
    n = 0;
    @(negedge CLK);
    while (!TX_VALID && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!TX_VALID) begin
      checks++;
      errors++;
      $display("[TB] FAIL tx_valid_wait: got 0, want 1");
    end
    b = TX_DATA;
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  first;
    logic [31:0] ops;
    int          rxStart;
    int          enStart;
    int          eStart;
    int          n;
    int          bad;

    vecs[0] = '{8'hA4, 4, 32'h000D_0007, 16'h0005, 16'h0007, 16'h000D, 4'h4};
    vecs[1] = '{8'hA0, 4, 32'h0001_0003, 16'h0004, 16'h0003, 16'h0001, 4'h0};
    vecs[2] = '{8'hAD, 2, 32'h0000_0003, 16'h0001, 16'h0003, 16'h0001, 4'hD};
    vecs[3] = '{8'hB2, 0, 32'h0000_0000, 16'h0003, 16'h0003, 16'h0001, 4'h2};
    vecs[4] = '{8'hA0, 4, 32'h0001_00FF, 16'h0100, 16'h00FF, 16'h0001, 4'h0};
    vecs[5] = '{8'hA1, 4, 32'h0003_0010, 16'h000D, 16'h0010, 16'h0003, 4'h1};

    RX_DATA  = 8'h00;
    RX_VALID = 1'b0;
    TX_READY = 1'b1;
    RST      = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_alu_fun", 32'(ALU_FUN), 32'hF);
    checkOutput("rst_tx_valid", 32'(TX_VALID), 0);
    checkOutput("rst_tx_data", 32'(TX_DATA), 0);
    checkOutput("rst_busy", 32'(BUSY), 0);
    checkOutput("rst_alu_en", 32'(ALU_EN), 0);
    checkOutput("rst_err", 32'(ERR), 0);
    checkOutput("rst_rx_ready", 32'(RX_READY), 0);
    checkOutput("rst_alu_a", 32'(ALU_A), 0);
    checkOutput("rst_alu_b", 32'(ALU_B), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Bad header: one ERR cycle, FSM stays idle, function untouched.
    eStart = errCount;
    applyStimulus(8'h55);
    checkOutput("bad_hdr_busy", 32'(BUSY), 0);
    repeat (3) @(negedge CLK);
    #1;
    checkOutput("bad_hdr_err_cycles", 32'(errCount - eStart), 1);
    checkOutput("bad_hdr_busy_later", 32'(BUSY), 0);
    checkOutput("bad_hdr_fun", 32'(ALU_FUN), 32'hF);
    @(posedge CLK); #1;

    for (int i = 0; i < 6; i++) begin
      rxStart = rxCount;
      enStart = enCount;
      applyStimulus(vecs[i].hdr);
      ops = vecs[i].ops;
      for (int j = 0; j < vecs[i].nOps; j++) applyStimulus(ops[8*j +: 8]);
      collectByte(lo);
      collectByte(hi);
      checkOutput($sformatf("f%0d_tx_lo", i), 32'(lo), 32'(vecs[i].expRes[7:0]));
      checkOutput($sformatf("f%0d_tx_hi", i), 32'(hi), 32'(vecs[i].expRes[15:8]));
      checkOutput($sformatf("f%0d_busy_end", i), 32'(BUSY), 0);
      checkOutput($sformatf("f%0d_rx_bytes", i), 32'(rxCount - rxStart), 32'(vecs[i].nOps + 1));
      checkOutput($sformatf("f%0d_alu_en_pulses", i), 32'(enCount - enStart), 1);
      checkOutput($sformatf("f%0d_alu_a", i), 32'(ALU_A), 32'(vecs[i].expA));
      checkOutput($sformatf("f%0d_alu_b", i), 32'(ALU_B), 32'(vecs[i].expB));
      checkOutput($sformatf("f%0d_alu_fun", i), 32'(ALU_FUN), 32'(vecs[i].expFun));
      checkOutput($sformatf("f%0d_en_latency", i), 32'(enCyc - lastAcc), 1);
      checkOutput($sformatf("f%0d_tx_latency", i), 32'(txRise - lastAcc), 3);
    end

    // Timeout after a partial frame: ERR pulse, back to IDLE, partial A kept.
    applyStimulus(8'hA0);
    applyStimulus(8'h11);
    n = 0;
    while (!ERR && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("to_err_seen", 32'(ERR), 1);
    checkOutput("to_cycle_window", 32'((n >= 255) && (n <= 257)), 1);
    checkOutput("to_busy", 32'(BUSY), 0);
    checkOutput("to_partial_a", 32'(ALU_A), 32'h0011);
    checkOutput("to_b_kept", 32'(ALU_B), 32'h0003);
    @(negedge CLK);
    checkOutput("to_err_one_cycle", 32'(ERR), 0);
    @(posedge CLK); #1;

    // Consumer stall in SEND_LO: byte must hold until accepted.
    TX_READY = 1'b0;
    applyStimulus(8'hA0);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    n = 0;
    @(negedge CLK);
    while (!TX_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    first = TX_DATA;
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (!TX_VALID || TX_DATA !== first) bad++;
    end
    checkOutput("stall_lo", 32'(first), 32'h05);
    checkOutput("stall_unstable_cycles", 32'(bad), 0);
    checkOutput("stall_busy", 32'(BUSY), 1);
    TX_READY = 1'b1;
    @(posedge CLK); #1;
    collectByte(hi);
    checkOutput("stall_hi", 32'(hi), 32'h00);
    checkOutput("stall_busy_end", 32'(BUSY), 0);

    // Reset during EXEC aborts immediately.
    applyStimulus(8'hA0);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    checkOutput("pre_rst_alu_en", 32'(ALU_EN), 1);
    #1 RST = 1'b1;
    #1;
    checkOutput("mid_rst_tx_valid", 32'(TX_VALID), 0);
    checkOutput("mid_rst_alu_fun", 32'(ALU_FUN), 32'hF);
    checkOutput("mid_rst_alu_en", 32'(ALU_EN), 0);
    checkOutput("mid_rst_busy", 32'(BUSY), 0);
    checkOutput("mid_rst_alu_a", 32'(ALU_A), 0);
    @(negedge CLK);
    RST = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge CLK);
      if (TX_VALID || BUSY) bad++;
    end
    checkOutput("post_rst_quiet_cycles", 32'(bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; the ports are named CLK and RST.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, the idle-cycle limit inside a frame.
REQ-003 Port: CLK  in  1  system clock; all state updates on the rising edge.
REQ-004 Port: RST  in  1  asynchronous active-high reset.
REQ-005 Port: RX_DATA  in  8  command/operand byte.
REQ-006 Port: RX_VALID  in  1  RX_DATA valid.
REQ-007 Port: RX_READY  out  1  byte accepted when RX_VALID and RX_READY are both 1 at a CLK edge.
REQ-008 Port: TX_DATA  out  8  result byte.
REQ-009 Port: TX_VALID  out  1  TX_DATA valid.
REQ-010 Port: TX_READY  in  1  consumer accepts when TX_VALID and TX_READY are both 1.
REQ-011 Port: ALU_A, ALU_B  out  16 each  registered operands to the ALU.
REQ-012 Port: ALU_FUN  out  4  registered ALU function code.
REQ-013 Port: ALU_EN  out  1  ALU clock-gate enable, high only in EXEC.
REQ-014 Port: ALU_OUT  in  16  registered ALU result, valid one cycle after the ALU_EN cycle.
REQ-015 Port: BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-016 Port: ERR  out  1  one-cycle pulse on a bad header or a timeout.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, GET_A0, GET_A1, GET_B0, GET_B1, EXEC, CAPT, SEND_LO, SEND_HI.
REQ-018 Frame format: a header byte, then operand bytes in the order A_lo, A_hi, B_lo, B_hi, each byte transferred through the RX handshake.
REQ-019 Header 0xA<f> SHALL latch ALU_FUN=f and go to GET_A0.
REQ-020 For shift codes f=4'b1101 or f=4'b1110, the FSM SHALL go from GET_A1 directly to EXEC and keep ALU_B unchanged.
REQ-021 Header 0xB<f> SHALL latch ALU_FUN=f, reuse the stored ALU_A and ALU_B, and go directly to EXEC.
REQ-022 Any other header SHALL pulse ERR for 1 cycle and keep the FSM in IDLE.
REQ-023 RX_READY SHALL be 1 only in IDLE, GET_A0, GET_A1, GET_B0 and GET_B1.
REQ-024 Latency: with the last operand accepted at edge N, ALU_EN SHALL be 1 for the cycle after N (EXEC); ALU_OUT SHALL be captured at the end of CAPT; TX_VALID SHALL rise in the cycle after CAPT.
REQ-025 SEND_LO SHALL present the result low byte and SEND_HI the high byte.
REQ-026 TX_DATA and TX_VALID SHALL hold stable until the handshake completes; after the high-byte handshake the FSM SHALL return to IDLE.
REQ-027 ALU_A, ALU_B and ALU_FUN SHALL change only on a byte or header accept, never during EXEC or CAPT.
REQ-028 Timeout: in the GET_* states, an 8-bit counter SHALL increment on each cycle with no accepted byte and clear on each accept.
REQ-029 When the counter reaches TIMEOUT, the block SHALL pulse ERR, go to IDLE, and leave the partial operands as loaded.
REQ-030 ALU_EN SHALL be 0 in every state except EXEC.
REQ-031 In IDLE, ALU_FUN SHALL keep its last value; the ALU is gated off by ALU_EN=0.

Reset
REQ-032 On RST, all outputs SHALL go to 0 except ALU_FUN, which SHALL go to 4'b1111 (the default, result 0).
REQ-033 On RST, the FSM SHALL go to IDLE, and the stored operands, result register and counter SHALL clear.
REQ-034 An RST asserted mid-frame or mid-send SHALL abort immediately, and no partial TX byte SHALL remain valid.

Structure
REQ-035 A shared package SHALL hold the state encoding, header nibbles (4'hA, 4'hB), shift function codes and the TIMEOUT default.
REQ-036 The timeout counter SHALL be one sub-module, alu_seq_timer, with inputs clear and run and output expired.

Verification
REQ-037 Bench: frame A0 03 00 01 00 -> one ALU_EN pulse, then TX bytes 04, 00, then BUSY=0.
REQ-038 Bench: frame AD 03 00 (right shift) -> no B bytes consumed, TX bytes 01, 00, ALU_B unchanged.
REQ-039 Bench: after REQ-038, header B2 -> TX equals stored A times stored B, and no operand bytes are requested.
REQ-040 Bench: header 55 -> ERR pulses for 1 cycle, BUSY stays 0, and the next frame A4 07 00 0D 00 returns 05, 00.
REQ-041 Bench: header A0 plus 1 byte, then 255 idle cycles -> ERR pulse and IDLE; hold TX_READY=0 for 10 cycles in SEND_LO -> TX_DATA stable.
REQ-042 Bench: RST asserted during EXEC -> TX_VALID=0, ALU_FUN=4'b1111 and ALU_EN=0 in the same cycle.
